// File: rtl/cmsdk_mcu_mtx_in_stage.sv
// Bus-matrix input stage: holds a master's address phase until an output arbiter accepts it, then relays the data-phase response.
// Latency: zero added cycles when accepted at once; otherwise one cycle after acceptance.
// Backpressure: HREADYOUTS low while a held transfer waits; mirrors the output stage's HREADYOUT during the data phase.
// Optional feature macro CMSDK_MTX_DEFSLV_EN: decode misses get a two-cycle ERROR response instead of aliasing to port 0.
module cmsdk_mcu_mtx_in_stage #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] REGION0    = 4'h0,
  parameter logic [3:0] REGION1    = 4'h2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  active_out,
  input  logic                  readyout_out,
  input  logic                  resp_out,
  output logic [ADDR_WIDTH-1:0] ADDR_o,
  output logic [1:0]            TRANS_o,
  output logic                  WRITE_o,
  output logic [2:0]            SIZE_o,
  output logic [2:0]            BURST_o,
  output logic [3:0]            PROT_o,
  output logic                  MASTLOCK_o,
  output logic                  req_port0,
  output logic                  req_port1,
  output logic                  HREADYOUTS,
  output logic                  HRESPS
);

`ifdef CMSDK_MTX_DEFSLV_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_DATA = 3'd2
  } state_t;
`endif

  state_t state_q, state_d;

  // Held copy of the address phase; only meaningful while in PEND.
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [1:0]            hold_trans_q, hold_trans_d;
  logic                  hold_write_q, hold_write_d;
  logic [2:0]            hold_size_q, hold_size_d;
  logic [2:0]            hold_burst_q, hold_burst_d;
  logic [3:0]            hold_prot_q, hold_prot_d;
  logic                  hold_lock_q, hold_lock_d;

  logic                  new_tran;
  logic                  accept;
  logic                  pend;
  logic                  capture;
  logic                  may_issue;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [3:0]            dec_nibble;
  logic                  hit0, hit1;
  logic                  hit0_eff, hit1_eff;
  logic                  req0_c, req1_c;
  logic                  hready_c, hresp_c;

  assign new_tran = HSELS & HREADYS & HTRANSS[1];
  assign accept   = active_out & readyout_out;
  assign pend     = (state_q == ST_PEND);

  // Decode follows whichever address is currently presented downstream.
  assign dec_addr   = pend ? hold_addr_q : HADDRS;
  assign dec_nibble = dec_addr[ADDR_WIDTH-1 -: 4];
  assign hit0       = (dec_nibble == REGION0);
  assign hit1       = (dec_nibble == REGION1);

`ifdef CMSDK_MTX_DEFSLV_EN
  // Misses are routed to the internal error responder, never to a port.
  logic miss;
  assign miss     = ~hit0 & ~hit1;
  assign hit0_eff = hit0;
  assign hit1_eff = hit1;
`else
  // Anything that is not port 1 aliases onto port 0.
  assign hit0_eff = hit0 | ~hit1;
  assign hit1_eff = hit1 & ~hit0;
`endif

  // Next-state, request and master-response decode; defaults first.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    may_issue = 1'b0;
    req0_c    = 1'b0;
    req1_c    = 1'b0;
    hready_c  = 1'b1;
    hresp_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        may_issue = 1'b1;
      end
      ST_PEND: begin
        hready_c = 1'b0;
        req0_c   = hit0_eff;
        req1_c   = hit1_eff;
        if (accept) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        hready_c  = readyout_out;
        hresp_c   = resp_out;
        // A completing data phase overlaps the next address phase.
        may_issue = readyout_out;
      end
`ifdef CMSDK_MTX_DEFSLV_EN
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = 1'b1;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        hready_c  = 1'b1;
        hresp_c   = 1'b1;
        may_issue = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Evaluate a fresh address phase wherever the master is allowed to issue.
    if (may_issue) begin
      state_d = ST_IDLE;
      if (new_tran) begin
`ifdef CMSDK_MTX_DEFSLV_EN
        if (miss) begin
          state_d = ST_ERR1;
        end else
`endif
        begin
          req0_c = hit0_eff;
          req1_c = hit1_eff;
          if (accept) begin
            state_d = ST_DATA;
          end else begin
            capture = 1'b1;
            state_d = ST_PEND;
          end
        end
      end
    end

    // Present a quiet, ready interface while reset is asserted.
    if (!HRESETn) begin
      req0_c   = 1'b0;
      req1_c   = 1'b0;
      hready_c = 1'b1;
      hresp_c  = 1'b0;
    end
  end

  // Hold register next-state: load the live address phase only on capture.
  always_comb begin
    hold_addr_d  = hold_addr_q;
    hold_trans_d = hold_trans_q;
    hold_write_d = hold_write_q;
    hold_size_d  = hold_size_q;
    hold_burst_d = hold_burst_q;
    hold_prot_d  = hold_prot_q;
    hold_lock_d  = hold_lock_q;
    if (capture) begin
      hold_addr_d  = HADDRS;
      hold_trans_d = HTRANSS;
      hold_write_d = HWRITES;
      hold_size_d  = HSIZES;
      hold_burst_d = HBURSTS;
      hold_prot_d  = HPROTS;
      hold_lock_d  = HMASTLOCKS;
    end
  end

  // State and hold register update with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      hold_addr_q  <= '0;
      hold_trans_q <= 2'b00;
      hold_write_q <= 1'b0;
      hold_size_q  <= 3'b000;
      hold_burst_q <= 3'b000;
      hold_prot_q  <= 4'b0000;
      hold_lock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_trans_q <= hold_trans_d;
      hold_write_q <= hold_write_d;
      hold_size_q  <= hold_size_d;
      hold_burst_q <= hold_burst_d;
      hold_prot_q  <= hold_prot_d;
      hold_lock_q  <= hold_lock_d;
    end
  end

  // Address phase to the output stages: held copy in PEND, live otherwise.
  assign ADDR_o     = pend ? hold_addr_q  : HADDRS;
  assign TRANS_o    = !HRESETn ? 2'b00 : (pend ? hold_trans_q : HTRANSS);
  assign WRITE_o    = pend ? hold_write_q : HWRITES;
  assign SIZE_o     = pend ? hold_size_q  : HSIZES;
  assign BURST_o    = pend ? hold_burst_q : HBURSTS;
  assign PROT_o     = pend ? hold_prot_q  : HPROTS;
  assign MASTLOCK_o = pend ? hold_lock_q  : HMASTLOCKS;

  assign req_port0  = req0_c;
  assign req_port1  = req1_c;
  assign HREADYOUTS = hready_c;
  assign HRESPS     = hresp_c;

endmodule

// File: doc/cmsdk_mcu_mtx_in_stage.md
Name: cmsdk_mcu_mtx_in_stage

Overview:
Bus-matrix input stage: one per AHB master port, directly upstream of the per-slave output arbiters. It registers the address phase when the target output port cannot accept it immediately and drives req_port0/req_port1 into the output arbiters. It stalls the master with HREADYOUTS until its held transfer is granted, then forwards the data-phase response back to the master.

Parameters:
ADDR_WIDTH, 32, address bus width
REGION0, 4'h0, HADDRS[ADDR_WIDTH-1:ADDR_WIDTH-4] value decoding to output port 0
REGION1, 4'h2, top-nibble value decoding to output port 1

Ports:
HCLK  in  1  AHB system clock
HRESETn  in  1  reset, synchronous, active-low
HSELS  in  1  input port select
HADDRS  in  ADDR_WIDTH  master address
HTRANSS  in  2  transfer type
HWRITES  in  1  write
HSIZES  in  3  size
HBURSTS  in  3  burst type
HPROTS  in  4  protection
HMASTLOCKS  in  1  locked transfer
HREADYS  in  1  bus-level HREADY seen by master
active_out  in  1  an output arbiter has this port as addr_in_port, and its no_port is low
readyout_out  in  1  HREADYOUT from the output stage owning this port's data phase
resp_out  in  1  HRESP from that output stage
ADDR_o, TRANS_o, WRITE_o, SIZE_o, BURST_o, PROT_o, MASTLOCK_o  out  as inputs  address phase to output stages; held copy when pending, else live
req_port0  out  1  request to output port 0
req_port1  out  1  request to output port 1
HREADYOUTS  out  1  ready to master
HRESPS  out  1  response to master

Behaviour:
- Definitions:
  - new_tran = HSELS & HREADYS & HTRANSS[1].
  - accept = active_out & readyout_out.
  - hit0 / hit1 = top-nibble decode against REGION0 / REGION1. Decode uses the held address in PEND, live HADDRS otherwise.
- States: IDLE, PEND, DATA; ERR1 and ERR2 exist only with the optional feature.
- IDLE:
  - HREADYOUTS=1, HRESPS=0.
  - new_tran & accept -> DATA (pass-through, zero added latency).
  - new_tran & !accept -> capture all address-phase inputs into hold register -> PEND.
- PEND:
  - HREADYOUTS=0, HRESPS=0.
  - Outputs driven from hold register.
  - req_portN=hitN (held address).
  - accept -> DATA.
- DATA:
  - HREADYOUTS=readyout_out, HRESPS=resp_out.
  - When readyout_out=1: new_tran & accept -> DATA; new_tran & !accept -> capture -> PEND; else -> IDLE.
  - When readyout_out=0: stay in DATA; no capture.
- Requests outside PEND: req_portN = new_tran & hitN (combinational from live inputs), in any state where the master may issue (IDLE, or DATA with readyout_out=1). Never asserted for IDLE/BUSY transfers or when HSELS=0.
- Hold register: loaded only on capture; contents stable throughout PEND. At most one outstanding transfer.
- HTRANSS IDLE/BUSY with HSELS=1: zero-wait OKAY, no request, no state change.
- Lock: MASTLOCK_o follows held/live value. Lock sequencing is the output arbiter's job.
- Reset (synchronous, any state, mid-transfer included): state=IDLE, hold register=0, req_port0/1=0, HREADYOUTS=1, HRESPS=0, TRANS_o=2'b00.
- Decode miss without the optional feature: aliased to port 0.
- Simultaneous readyout_out and new_tran in DATA: the new address phase is evaluated the same cycle (pipelined).

Optional Feature:
CMSDK_MTX_DEFSLV_EN
- Defined: a decode miss on new_tran (or in DATA with readyout_out=1) issues no request and goes to ERR1, then ERR2.
  - ERR1: HREADYOUTS=0, HRESPS=1.
  - ERR2: HREADYOUTS=1, HRESPS=1.
  - Then IDLE; a new_tran in the ERR2 cycle is evaluated as in IDLE.
- Not defined: ERR states absent; misses go to port 0.

Test Plan:
- Pass-through: HADDRS=0x0000_1000 NONSEQ, active_out=1, readyout_out=1 -> req_port0=1 same cycle, DATA next cycle, HREADYOUTS=1, no wait.
- Hold: HADDRS=0x2000_0040 NONSEQ write, active_out=0 for 3 cycles -> PEND, HREADYOUTS=0 for 3 cycles, ADDR_o=0x2000_0040 stable, req_port1=1. After active_out=1 -> DATA.
- Back-to-back: in DATA with readyout_out=1, new NONSEQ to 0x0000_0004, active_out=0 -> captured, PEND next cycle, HREADYOUTS=0.
- Wait/error pass: DATA with readyout_out=0 for 2 cycles then resp_out=1 -> HREADYOUTS mirrors 0,0,1 and HRESPS mirrors resp_out.
- Reset in PEND: HRESETn=0 at a rising edge -> next cycle IDLE, req_port0/1=0, HREADYOUTS=1, TRANS_o=0.
- CMSDK_MTX_DEFSLV_EN: NONSEQ to 0xF000_0000 -> no request; HREADYOUTS/HRESPS = 0/1 then 1/1; without the macro, req_port0=1.
